// File: rtl/config_bus_writer.sv
// Transmit side of the config_addr/config_data broadcast bus: collects an AXI-Stream
// header + payload from the PS, publishes the payload, then strobes the target address.
module config_bus_writer #(
    parameter int          CFG_WORDS = 16,
    parameter int          CFG_HOLD  = 2,
    parameter logic [31:0] IDLE_ADDR = 32'd0
) (
    input  logic                    a_clk,
    input  logic                    a_resetn,
    input  logic [31:0]             S_AXIS_CFG_tdata,
    input  logic                    S_AXIS_CFG_tvalid,
    output logic                    S_AXIS_CFG_tready,
    input  logic                    S_AXIS_CFG_tlast,
    output logic [31:0]             config_addr,
    output logic [32*CFG_WORDS-1:0] config_data,
    output logic                    busy,
    output logic [15:0]             commit_count,
    output logic [2:0]              err_flags,
    input  logic                    err_clr
);

    localparam int IDX_W  = $clog2(CFG_WORDS + 1);
    localparam int WSEL_W = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
    localparam int HOLD_W = (CFG_HOLD > 1) ? $clog2(CFG_HOLD) : 1;
    localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(CFG_WORDS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CFG_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DROP,
        S_COMMIT,
        S_STROBE,
        S_GAP
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [IDX_W-1:0]             idx;
    logic [HOLD_W-1:0]            hold_cnt;
    logic [31:0]                  target;
    logic [CFG_WORDS-1:0][31:0]   shadow;
    logic [2:0]                   err_set;
    logic                         beat;

    assign beat = S_AXIS_CFG_tvalid & S_AXIS_CFG_tready;
    assign busy = (state != S_IDLE);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        err_set   = 3'b000;
        case (state)
            S_IDLE: begin
                if (beat) begin
                    if (S_AXIS_CFG_tlast) begin
                        err_set[1] = 1'b1;
                        err_set[2] = (S_AXIS_CFG_tdata == IDLE_ADDR);
                    end else if (S_AXIS_CFG_tdata == IDLE_ADDR) begin
                        err_set[2] = 1'b1;
                        state_nxt  = S_DROP;
                    end else begin
                        state_nxt  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    err_set[0] = (idx == IDX_FULL);
                    if (S_AXIS_CFG_tlast) state_nxt = S_COMMIT;
                end
            end
            S_DROP:   if (beat && S_AXIS_CFG_tlast) state_nxt = S_IDLE;
            S_COMMIT: state_nxt = S_STROBE;
            S_STROBE: if (hold_cnt == HOLD_LAST) state_nxt = S_GAP;
            S_GAP:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only, so every register here samples pre-edge values.
    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            state             <= S_IDLE;
            S_AXIS_CFG_tready <= 1'b1;
            config_addr       <= IDLE_ADDR;
            config_data       <= '0;
            shadow            <= '0;
            target            <= '0;
            idx               <= '0;
            hold_cnt          <= '0;
            commit_count      <= '0;
            err_flags         <= '0;
        end else begin
            state             <= state_nxt;
            S_AXIS_CFG_tready <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD) ||
                                 (state_nxt == S_DROP);
            // The address lags the state by one cycle so config_data settles before it.
            config_addr       <= (state == S_STROBE) ? target : IDLE_ADDR;
            err_flags         <= (err_clr ? 3'b000 : err_flags) | err_set;

            case (state)
                S_IDLE: begin
                    if (beat) begin
                        target <= S_AXIS_CFG_tdata;
                        shadow <= '0;
                        idx    <= '0;
                    end
                end
                S_LOAD: begin
                    if (beat && (idx != IDX_FULL)) begin
                        shadow[idx[WSEL_W-1:0]] <= S_AXIS_CFG_tdata;
                        idx                     <= idx + 1'b1;
                    end
                end
                S_COMMIT: begin
                    config_data <= shadow;
                    hold_cnt    <= '0;
                end
                S_STROBE: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) commit_count <= commit_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_bus_writer.sv
// Randomized + directed bench for config_bus_writer; a transaction-level model predicts
// every output each cycle from the accepted beats and the documented latencies.
module tb_config_bus_writer;

    localparam int          CFG_WORDS = 16;
    localparam int          CFG_HOLD  = 2;
    localparam logic [31:0] IDLE_ADDR = 32'd0;

    logic         a_clk = 1'b0;
    logic         a_resetn = 1'b0;
    logic [31:0]  tdata = '0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic         err_clr = 1'b0;
    logic         tready;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic         busy;
    logic [15:0]  commit_count;
    logic [2:0]   err_flags;

    config_bus_writer #(
        .CFG_WORDS(CFG_WORDS),
        .CFG_HOLD (CFG_HOLD),
        .IDLE_ADDR(IDLE_ADDR)
    ) dut (
        .a_clk            (a_clk),
        .a_resetn         (a_resetn),
        .S_AXIS_CFG_tdata (tdata),
        .S_AXIS_CFG_tvalid(tvalid),
        .S_AXIS_CFG_tready(tready),
        .S_AXIS_CFG_tlast (tlast),
        .config_addr      (config_addr),
        .config_data      (config_data),
        .busy             (busy),
        .commit_count     (commit_count),
        .err_flags        (err_flags),
        .err_clr          (err_clr)
    );

    always #5 a_clk = ~a_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference model.
    typedef enum {M_HDR, M_COLLECT, M_DISCARD} mode_t;
    mode_t        m_mode = M_HDR;
    logic [31:0]  m_target = '0;
    logic [31:0]  m_words[$];
    logic [511:0] m_payload = '0;
    int           m_since = -1;
    bit           live = 1'b0;
    logic [511:0] exp_data = '0;
    logic [31:0]  exp_addr = '0;
    logic         exp_ready = 1'b1;
    logic [15:0]  exp_count = '0;
    logic [2:0]   exp_err = '0;
    int           strobe_cycles = 0;
    int           ready_low = 0;
    int           busy_cycles = 0;

    function automatic logic [511:0] pack(input logic [31:0] w[$]);
        logic [511:0] p = '0;
        for (int k = 0; k < w.size() && k < CFG_WORDS; k++) p[32*k +: 32] = w[k];
        return p;
    endfunction

    task automatic model_step();
        logic       acc;
        logic [2:0] new_err;
        if (!a_resetn) begin
            exp_data = '0; exp_addr = IDLE_ADDR; exp_ready = 1'b1;
            exp_count = '0; exp_err = '0;
            m_mode = M_HDR; m_since = -1; m_words.delete();
            live = 1'b1;
            return;
        end
        acc     = tvalid && exp_ready;
        new_err = 3'b000;
        if (m_since >= 0) begin
            m_since++;
            if (m_since == 1) exp_data = m_payload;
            if (m_since == 2) exp_addr = m_target;
            if (m_since == CFG_HOLD + 1) exp_count = exp_count + 16'd1;
            if (m_since == CFG_HOLD + 2) begin
                exp_addr = IDLE_ADDR; exp_ready = 1'b1; m_since = -1;
            end
        end
        if (acc) begin
            case (m_mode)
                M_HDR: begin
                    if (tlast) begin
                        new_err[1] = 1'b1;
                        if (tdata == IDLE_ADDR) new_err[2] = 1'b1;
                    end else if (tdata == IDLE_ADDR) begin
                        new_err[2] = 1'b1; m_mode = M_DISCARD;
                    end else begin
                        m_target = tdata; m_words.delete(); m_mode = M_COLLECT;
                    end
                end
                M_COLLECT: begin
                    if (m_words.size() < CFG_WORDS) m_words.push_back(tdata);
                    else new_err[0] = 1'b1;
                    if (tlast) begin
                        m_payload = pack(m_words);
                        m_mode = M_HDR; m_since = 0; exp_ready = 1'b0;
                    end
                end
                M_DISCARD: if (tlast) m_mode = M_HDR;
                default: ;
            endcase
        end
        exp_err = (err_clr ? 3'b000 : exp_err) | new_err;
    endtask

    always @(negedge a_clk) begin
        if (live) begin
            check("config_addr", config_addr, exp_addr);
            check("config_data", config_data, exp_data);
            check("tready", tready, exp_ready);
            check("busy", busy, (m_mode != M_HDR) || (m_since >= 0));
            check("commit_count", commit_count, exp_count);
            check("err_flags", err_flags, exp_err);
            if (a_resetn) begin
                if (config_addr !== IDLE_ADDR) strobe_cycles++;
                if (tready !== 1'b1) ready_low++;
                if (busy === 1'b1) busy_cycles++;
            end
        end
        model_step();
    end

    // Driver: tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input logic [31:0] d, input logic last, input int max_gap);
        int g;
        int budget;
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (g) begin
            tvalid = 1'b0; tlast = 1'b0;
            @(posedge a_clk); #1;
        end
        tvalid = 1'b1; tdata = d; tlast = last;
        budget = 0;
        @(negedge a_clk);
        while (!tready) begin
            budget++;
            if (budget > 50) begin
                check("tready_timeout", 0, 1);
                tvalid = 1'b0; tlast = 1'b0;
                @(posedge a_clk); #1;
                return;
            end
            @(negedge a_clk);
        end
        @(posedge a_clk); #1;
    endtask

    task automatic send_txn(input logic [31:0] hdr, input logic [31:0] w[$], input int max_gap);
        send_beat(hdr, w.size() == 0, max_gap);
        foreach (w[k]) send_beat(w[k], k == w.size() - 1, max_gap);
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0; tlast = 1'b0;
        repeat (n) begin @(posedge a_clk); #1; end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge a_clk); #1;
        err_clr = 1'b0;
    endtask

    task automatic rand_words(input int n, output logic [31:0] w[$]);
        w.delete();
        repeat (n) w.push_back($urandom);
    endtask

    initial begin
        logic [31:0]  w[$];
        logic [31:0]  w2[$];
        logic [511:0] saved;
        int s0, r0, b0;

        repeat (3) @(posedge a_clk);
        #1 a_resetn = 1'b1;
        idle(2);

        // Three-word write to 20030.
        s0 = strobe_cycles; r0 = ready_low;
        w.delete(); w.push_back(32'd1); w.push_back(32'h1234); w.push_back(32'h0800);
        send_txn(32'd20030, w, 0);
        idle(8);
        check("t1_data", config_data, 512'h00000800_00001234_00000001);
        check("t1_strobe_cycles", strobe_cycles - s0, 2);
        check("t1_ready_low", ready_low - r0, 4);
        check("t1_count", commit_count, 16'd1);

        // Back-to-back with tvalid held high; second payload shorter.
        s0 = strobe_cycles; r0 = ready_low;
        rand_words(5, w); rand_words(2, w2);
        send_txn(32'd20030, w, 0);
        send_txn(32'd20031, w2, 0);
        idle(10);
        check("t2_data", config_data, pack(w2));
        check("t2_strobe_cycles", strobe_cycles - s0, 4);
        check("t2_ready_low", ready_low - r0, 8);
        check("t2_count", commit_count, 16'd3);

        // Overflow: 18 words, last two dropped.
        rand_words(18, w);
        send_txn(32'hABCD_0001, w, 1);
        idle(8);
        saved = pack(w);
        check("t3_data", config_data, saved);
        check("t3_err", err_flags, 3'b001);
        check("t3_count", commit_count, 16'd4);
        pulse_clr();
        check("t3_err_clr", err_flags, 3'b000);

        // Reserved header: consumed, no strobe.
        s0 = strobe_cycles;
        rand_words(3, w);
        send_txn(IDLE_ADDR, w, 1);
        idle(8);
        check("t4_data", config_data, saved);
        check("t4_err", err_flags, 3'b100);
        check("t4_strobe_cycles", strobe_cycles - s0, 0);
        pulse_clr();
        check("t4_err_clr", err_flags, 3'b000);

        // Header-only beat, err_clr asserted in the same cycle: the new error wins.
        s0 = strobe_cycles; b0 = busy_cycles;
        err_clr = 1'b1;
        send_beat(32'h55, 1'b1, 0);
        err_clr = 1'b0;
        idle(6);
        check("t5_err", err_flags, 3'b010);
        check("t5_busy_cycles", busy_cycles - b0, 0);
        check("t5_strobe_cycles", strobe_cycles - s0, 0);
        pulse_clr();

        // Reset in the middle of LOAD.
        send_beat(32'h77, 1'b0, 0);
        for (int k = 0; k < 5; k++) send_beat($urandom, 1'b0, 0);
        tvalid = 1'b0;
        a_resetn = 1'b0;
        @(posedge a_clk); #1;
        a_resetn = 1'b1;
        check("t6_addr", config_addr, IDLE_ADDR);
        check("t6_data", config_data, 512'd0);
        check("t6_busy", busy, 1'b0);
        check("t6_count", commit_count, 16'd0);
        rand_words(4, w);
        send_txn(32'h99, w, 0);
        idle(8);
        check("t6_after_data", config_data, pack(w));
        check("t6_after_count", commit_count, 16'd1);

        // Randomized traffic; the per-cycle model carries the checks.
        for (int t = 0; t < 40; t++) begin
            int kind;
            logic [31:0] hdr;
            kind = $urandom_range(9, 0);
            hdr  = $urandom;
            if (hdr == IDLE_ADDR) hdr = 32'd1;
            if (kind == 0) begin
                rand_words($urandom_range(4, 1), w);
                send_txn(IDLE_ADDR, w, 2);
            end else if (kind == 1) begin
                w.delete();
                send_txn(hdr, w, 2);
            end else begin
                rand_words($urandom_range(20, 1), w);
                send_txn(hdr, w, 2);
            end
            if ($urandom_range(3, 0) == 0) pulse_clr();
            idle($urandom_range(3, 0));
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
